// File: rtl/ddr4_mc_ecc_err_log.sv
// ddr4_mc_ecc_err_log: counts ECC CE/UE beats, captures first error address per class, raises a level interrupt
module ddr4_mc_ecc_err_log #(
  parameter int TCQ             = 100,
  parameter int nCK_PER_CLK     = 4,
  parameter int ADDR_FIFO_WIDTH = 52,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [2*nCK_PER_CLK-1:0]     i_ecc_single,
  input  logic [2*nCK_PER_CLK-1:0]     i_ecc_multiple,
  input  logic [ADDR_FIFO_WIDTH-1:0]   i_ecc_err_addr,
  input  logic [CNT_WIDTH-1:0]         i_ce_thresh,
  input  logic                         i_ce_irq_en,
  input  logic                         i_ue_irq_en,
  input  logic                         i_clr_ce,
  input  logic                         i_clr_ue,
  output logic [CNT_WIDTH-1:0]         o_ce_cnt,
  output logic [CNT_WIDTH-1:0]         o_ue_cnt,
  output logic [ADDR_FIFO_WIDTH-1:0]   o_ce_addr,
  output logic [ADDR_FIFO_WIDTH-1:0]   o_ue_addr,
  output logic [2*nCK_PER_CLK-1:0]     o_ce_beats,
  output logic [2*nCK_PER_CLK-1:0]     o_ue_beats,
  output logic                         o_ce_valid,
  output logic                         o_ue_valid,
  output logic                         o_ce_ovfl,
  output logic                         o_ue_ovfl,
  output logic                         o_ecc_irq
);
  localparam int NB = 2 * nCK_PER_CLK;
  localparam int SW = CNT_WIDTH + 4;
  // flop timing is modelled by the registers themselves; TCQ is kept only for interface compatibility
  logic w_unused_tcq;
  assign w_unused_tcq = ^TCQ;
  // a beat flagged in both vectors is treated as uncorrectable only
  logic [NB-1:0] w_ce_mask, w_ue_mask;
  assign w_ce_mask = i_ecc_single & ~i_ecc_multiple;
  assign w_ue_mask = i_ecc_multiple;
  // class 0 = CE, class 1 = UE; identical counter + capture FSM per class
  for (genvar c = 0; c < 2; c++) begin : g_cls
    typedef enum logic [1:0] {EMPTY, HELD, OVFL} state_t;
    state_t                       r_state, w_state_nxt;
    logic [NB-1:0]                w_m;
    logic                         w_clr, w_evt, w_load, w_valid_nxt;
    logic [SW-1:0]                w_pop, w_sum;
    logic [CNT_WIDTH-1:0]         w_base, w_cnt_nxt;
    logic [CNT_WIDTH-1:0]         r_cnt;
    logic [ADDR_FIFO_WIDTH-1:0]   r_addr;
    logic [NB-1:0]                r_beats;
    logic                         r_valid, r_ovfl;
    assign w_m   = (c == 0) ? w_ce_mask : w_ue_mask;
    assign w_clr = (c == 0) ? i_clr_ce : i_clr_ue;
    assign w_evt = |w_m;
    // population count of this cycle's flagged beats
    always_comb begin
      w_pop = '0;
      for (int b = 0; b < NB; b++) w_pop = w_pop + SW'(w_m[b]);
    end
    // clear applies before the event, so a colliding event restarts the count from zero
    assign w_base      = w_clr ? '0 : r_cnt;
    assign w_sum       = SW'(w_base) + w_pop;
    assign w_cnt_nxt   = (|w_sum[SW-1:CNT_WIDTH]) ? '1 : w_sum[CNT_WIDTH-1:0];
    assign w_state_nxt = w_clr ? (w_evt ? HELD : EMPTY) :
                         !w_evt ? r_state :
                         (r_state == EMPTY) ? HELD : OVFL;
    assign w_load      = w_evt & (w_clr | (r_state == EMPTY));
    assign w_valid_nxt = w_state_nxt != EMPTY;
    // capture FSM with registered count, address, beat mask and status flags
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_state <= EMPTY;
        r_cnt   <= '0;
        r_addr  <= '0;
        r_beats <= '0;
        r_valid <= 1'b0;
        r_ovfl  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_valid <= w_valid_nxt;
        r_ovfl  <= w_state_nxt == OVFL;
        if (w_load) begin
          r_addr  <= i_ecc_err_addr;
          r_beats <= w_m;
        end else if (w_clr) begin
          r_addr  <= '0;
          r_beats <= '0;
        end
      end
    end
  end
  assign o_ce_cnt   = g_cls[0].r_cnt;
  assign o_ue_cnt   = g_cls[1].r_cnt;
  assign o_ce_addr  = g_cls[0].r_addr;
  assign o_ue_addr  = g_cls[1].r_addr;
  assign o_ce_beats = g_cls[0].r_beats;
  assign o_ue_beats = g_cls[1].r_beats;
  assign o_ce_valid = g_cls[0].r_valid;
  assign o_ue_valid = g_cls[1].r_valid;
  assign o_ce_ovfl  = g_cls[0].r_ovfl;
  assign o_ue_ovfl  = g_cls[1].r_ovfl;
  logic w_irq_nxt;
  assign w_irq_nxt = (i_ce_irq_en & (i_ce_thresh != '0) & (g_cls[0].w_cnt_nxt >= i_ce_thresh)) |
                     (i_ue_irq_en & g_cls[1].w_valid_nxt);
  // level interrupt, registered from next-state counts so it tracks the outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_ecc_irq <= 1'b0;
    else          o_ecc_irq <= w_irq_nxt;
  end
endmodule

// File: tb/tb_ddr4_mc_ecc_err_log.sv
// tb_ddr4_mc_ecc_err_log: directed self-checking bench for the ECC error logger
module tb_ddr4_mc_ecc_err_log;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  single = '0, multiple = '0;
  logic [51:0] addr = '0;
  logic [15:0] thresh = '0;
  logic        ce_en = 1'b0, ue_en = 1'b0, clr_ce = 1'b0, clr_ue = 1'b0;
  logic [15:0] ce_cnt, ue_cnt;
  logic [51:0] ce_addr, ue_addr;
  logic [7:0]  ce_beats, ue_beats;
  logic        ce_valid, ue_valid, ce_ovfl, ue_ovfl, irq;
  logic [3:0]  s_ce_cnt, s_ue_cnt;
  logic [51:0] s_ce_addr, s_ue_addr;
  logic [7:0]  s_ce_beats, s_ue_beats;
  logic        s_ce_valid, s_ue_valid, s_ce_ovfl, s_ue_ovfl, s_irq;
  int          errors = 0, checks = 0;
  localparam logic [51:0] A = 52'h1_2345_6789_ABCD;
  localparam logic [51:0] B = 52'hF_EDCB_A987_6543;
  localparam logic [51:0] C = 52'h0_00C0_FFEE_0C0C;
  localparam logic [51:0] D = 52'h5_5555_AAAA_5555;

  always #5 clk = ~clk;

  ddr4_mc_ecc_err_log dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ecc_single(single), .i_ecc_multiple(multiple),
    .i_ecc_err_addr(addr), .i_ce_thresh(thresh), .i_ce_irq_en(ce_en), .i_ue_irq_en(ue_en),
    .i_clr_ce(clr_ce), .i_clr_ue(clr_ue), .o_ce_cnt(ce_cnt), .o_ue_cnt(ue_cnt),
    .o_ce_addr(ce_addr), .o_ue_addr(ue_addr), .o_ce_beats(ce_beats), .o_ue_beats(ue_beats),
    .o_ce_valid(ce_valid), .o_ue_valid(ue_valid), .o_ce_ovfl(ce_ovfl), .o_ue_ovfl(ue_ovfl),
    .o_ecc_irq(irq));

  ddr4_mc_ecc_err_log #(.CNT_WIDTH(4)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_ecc_single(single), .i_ecc_multiple(multiple),
    .i_ecc_err_addr(addr), .i_ce_thresh(4'd0), .i_ce_irq_en(ce_en), .i_ue_irq_en(ue_en),
    .i_clr_ce(clr_ce), .i_clr_ue(clr_ue), .o_ce_cnt(s_ce_cnt), .o_ue_cnt(s_ue_cnt),
    .o_ce_addr(s_ce_addr), .o_ue_addr(s_ue_addr), .o_ce_beats(s_ce_beats), .o_ue_beats(s_ue_beats),
    .o_ce_valid(s_ce_valid), .o_ue_valid(s_ue_valid), .o_ce_ovfl(s_ce_ovfl), .o_ue_ovfl(s_ue_ovfl),
    .o_ecc_irq(s_irq));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [7:0] s, input logic [7:0] m, input logic [51:0] a,
                     input logic cc, input logic cu);
    single = s; multiple = m; addr = a; clr_ce = cc; clr_ue = cu;
    @(posedge clk);
    #1;
    single = '0; multiple = '0; addr = '0; clr_ce = 1'b0; clr_ue = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("rst_ce_cnt", ce_cnt, 0);
    chk("rst_irq", irq, 0);
    cyc(8'h1F, 8'h00, D, 0, 0);
    chk("pre_async_cnt5", ce_cnt, 5);
    #3 rst_n = 1'b0;
    #1;
    chk("async_ce_cnt", ce_cnt, 0);
    chk("async_ce_valid", ce_valid, 0);
    chk("async_ce_addr", ce_addr, 0);
    chk("async_s_ce_cnt", s_ce_cnt, 0);
    #1 rst_n = 1'b1;
    cyc(8'h01, 8'h00, D, 0, 0);
    chk("post_rst_cnt", ce_cnt, 1);
    chk("post_rst_valid", ce_valid, 1);
    cyc(8'h00, 8'h00, '0, 1, 0);
    chk("clr_ce_cnt", ce_cnt, 0);
    chk("clr_ce_valid", ce_valid, 0);
    cyc(8'h03, 8'h00, A, 0, 0);
    chk("cap_cnt", ce_cnt, 2);
    chk("cap_addr", ce_addr, A);
    chk("cap_beats", ce_beats, 8'h03);
    chk("cap_ovfl0", ce_ovfl, 0);
    cyc(8'h80, 8'h00, B, 0, 0);
    chk("ovfl_cnt", ce_cnt, 3);
    chk("ovfl_addr", ce_addr, A);
    chk("ovfl_beats", ce_beats, 8'h03);
    chk("ovfl_flag", ce_ovfl, 1);
    chk("ovfl_ue_untouched", ue_valid, 0);
    cyc(8'h00, 8'h0F, D, 0, 0);
    chk("ue_cnt4", ue_cnt, 4);
    chk("ue_valid", ue_valid, 1);
    cyc(8'h00, 8'h10, C, 0, 1);
    chk("coll_ue_cnt", ue_cnt, 1);
    chk("coll_ue_addr", ue_addr, C);
    chk("coll_ue_beats", ue_beats, 8'h10);
    chk("coll_ue_valid", ue_valid, 1);
    chk("coll_ue_ovfl", ue_ovfl, 0);
    chk("coll_ce_kept", ce_cnt, 3);
    cyc(8'h00, 8'h00, '0, 1, 1);
    thresh = 16'd3; ce_en = 1'b1;
    cyc(8'h07, 8'h04, B, 0, 0);
    chk("ovl_ce_cnt", ce_cnt, 2);
    chk("ovl_ue_cnt", ue_cnt, 1);
    chk("ovl_ce_beats", ce_beats, 8'h03);
    chk("ovl_ue_addr", ue_addr, B);
    chk("ovl_irq0", irq, 0);
    ue_en = 1'b1;
    cyc(8'h00, 8'h00, '0, 0, 0);
    chk("ue_en_irq1", irq, 1);
    cyc(8'h00, 8'h00, '0, 0, 1);
    chk("clr_ue_irq0", irq, 0);
    chk("clr_ue_valid", ue_valid, 0);
    chk("clr_ue_ce_cnt", ce_cnt, 2);
    cyc(8'h01, 8'h00, A, 0, 0);
    chk("thresh_eq_irq", irq, 1);
    ce_en = 1'b0;
    cyc(8'h00, 8'h00, '0, 0, 0);
    chk("ce_dis_irq0", irq, 0);
    ue_en = 1'b0;
    cyc(8'h00, 8'h00, '0, 1, 0);
    cyc(8'hFF, 8'h00, A, 0, 0);
    cyc(8'h3F, 8'h00, A, 0, 0);
    chk("sat_pre14", s_ce_cnt, 14);
    cyc(8'hFF, 8'h00, A, 0, 0);
    chk("sat_15", s_ce_cnt, 15);
    chk("sat_wide22", ce_cnt, 22);
    cyc(8'h01, 8'h00, A, 0, 0);
    chk("sat_hold15", s_ce_cnt, 15);
    chk("sat_wide23", ce_cnt, 23);
    cyc(8'h00, 8'h00, '0, 1, 0);
    thresh = 16'd0; ce_en = 1'b1;
    for (int i = 0; i < 12; i++) cyc(8'hFF, 8'h00, C, 0, 0);
    cyc(8'h0F, 8'h00, C, 0, 0);
    chk("dis_cnt100", ce_cnt, 100);
    chk("dis_irq0", irq, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
